// File: rtl/sample_recorder.sv
// Capture buffer: records a valid/ready sample stream into a circular RAM around a trigger event,
// then replays the captured window oldest-first as an output stream with tlast.
module sample_recorder #(
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int SAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SEW-1:0] cfg_evt_trg,
    input  logic [SAW-1:0] cfg_post,
    input  logic           ctl_arm,
    input  logic           ctl_abort,
    output logic [1:0]     sts_state,
    output logic [SAW-1:0] sts_trg_adr,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SEW-1:0] sto_tevent,
    output logic [SDW-1:0] sto_tdata
);

    localparam int DW    = SEW + SDW;
    localparam int DEPTH = 2 ** SAW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        READ = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [SAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [SAW:0]   cnt_q, cnt_d;
    logic [SAW-1:0] post_q, post_d;
    logic [SAW-1:0] trg_adr_q, trg_adr_d;
    logic [SAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SAW:0]   left_q, left_d;
    logic           inflight_q, inflight_d;
    logic           inflight_last_q, inflight_last_d;
    logic [1:0]     fcnt_q, fcnt_d;
    logic [DW-1:0]  e0_q, e0_d, e1_q, e1_d;
    logic           l0_q, l0_d, l1_q, l1_d;

    logic [DW-1:0]  mem [DEPTH];
    logic [DW-1:0]  rd_data_q;

    logic           in_xfer, wr_en, trig, pop, issue, go_read;
    logic [1:0]     occ;

    assign sti_tready  = (state_q != READ);
    assign in_xfer     = sti_tvalid & sti_tready;
    assign wr_en       = in_xfer & ((state_q == PRE) | (state_q == POST));
    assign trig        = |(sti_tevent & cfg_evt_trg);
    assign sto_tvalid  = (fcnt_q != 2'd0);
    assign pop         = sto_tvalid & sto_tready;
    // Occupancy the skid will hold after this cycle; a read issued now lands one cycle later.
    assign occ         = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue       = (state_q == READ) & (left_q != '0) & (occ <= 2'd1) & ~ctl_abort;

    assign sts_state   = state_q;
    assign sts_trg_adr = trg_adr_q;
    assign sto_tlast   = l0_q & sto_tvalid;
    assign sto_tevent  = e0_q[DW-1 -: SEW];
    assign sto_tdata   = e0_q[SDW-1:0];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        post_d    = post_q;
        trg_adr_d = trg_adr_q;
        rd_ptr_d  = rd_ptr_q;
        left_d    = left_q;
        go_read   = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + SAW'(1);
            cnt_d    = cnt_q[SAW] ? cnt_q : cnt_q + (SAW+1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (ctl_arm) begin
                    state_d  = PRE;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    post_d   = '0;
                end
            end
            PRE: begin
                if (in_xfer && trig) begin
                    trg_adr_d = wr_ptr_q;
                    if (cfg_post == '0) begin
                        go_read = 1'b1;
                    end else begin
                        post_d  = cfg_post;
                        state_d = POST;
                    end
                end
            end
            POST: begin
                if (in_xfer) begin
                    post_d = post_q - SAW'(1);
                    if (post_q == SAW'(1)) begin
                        go_read = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + SAW'(1);
                    left_d   = left_q - (SAW+1)'(1);
                end
                if (pop && l0_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Once the buffer has filled, the write pointer marks the oldest entry.
        if (go_read) begin
            state_d  = READ;
            rd_ptr_d = cnt_d[SAW] ? wr_ptr_d : '0;
            left_d   = cnt_d;
        end

        if (ctl_abort) begin
            state_d = IDLE;
            left_d  = '0;
        end
    end

    always_comb begin
        fcnt_d          = fcnt_q;
        e0_d            = e0_q;
        e1_d            = e1_q;
        l0_d            = l0_q;
        l1_d            = l1_q;
        inflight_d      = issue;
        inflight_last_d = issue ? (left_q == (SAW+1)'(1)) : inflight_last_q;

        case ({inflight_q, pop})
            2'b10: begin
                if (fcnt_q == 2'd0) begin
                    e0_d = rd_data_q;
                    l0_d = inflight_last_q;
                end else begin
                    e1_d = rd_data_q;
                    l1_d = inflight_last_q;
                end
                fcnt_d = fcnt_q + 2'd1;
            end
            2'b01: begin
                e0_d   = e1_q;
                l0_d   = l1_q;
                fcnt_d = fcnt_q - 2'd1;
            end
            2'b11: begin
                if (fcnt_q == 2'd1) begin
                    e0_d = rd_data_q;
                    l0_d = inflight_last_q;
                end else begin
                    e0_d = e1_q;
                    l0_d = l1_q;
                    e1_d = rd_data_q;
                    l1_d = inflight_last_q;
                end
            end
            default: ;
        endcase

        if (ctl_abort) begin
            fcnt_d     = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            cnt_q           <= '0;
            post_q          <= '0;
            trg_adr_q       <= '0;
            rd_ptr_q        <= '0;
            left_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fcnt_q          <= 2'd0;
            e0_q            <= '0;
            e1_q            <= '0;
            l0_q            <= 1'b0;
            l1_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            cnt_q           <= cnt_d;
            post_q          <= post_d;
            trg_adr_q       <= trg_adr_d;
            rd_ptr_q        <= rd_ptr_d;
            left_q          <= left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fcnt_q          <= fcnt_d;
            e0_q            <= e0_d;
            e1_q            <= e1_d;
            l0_q            <= l0_d;
            l1_q            <= l1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {sti_tevent, sti_tdata};
        end
        if (issue) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_sample_recorder.sv
// Directed bench for sample_recorder: capture, wrap, post=0, stalled readout, abort and re-arm.
module tb_sample_recorder;

    localparam int SDW = 32;
    localparam int SEW = 2;
    localparam int SAW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [SEW-1:0] cfg_evt_trg;
    logic [SAW-1:0] cfg_post;
    logic           ctl_arm, ctl_abort;
    logic [1:0]     sts_state;
    logic [SAW-1:0] sts_trg_adr;
    logic           sti_tready, sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;
    logic           sto_tready, sto_tvalid, sto_tlast;
    logic [SEW-1:0] sto_tevent;
    logic [SDW-1:0] sto_tdata;

    int checks = 0;
    int errors = 0;

    sample_recorder #(.SDW(SDW), .SEW(SEW), .SAW(SAW)) dut (
        .clk(clk), .rst(rst),
        .cfg_evt_trg(cfg_evt_trg), .cfg_post(cfg_post),
        .ctl_arm(ctl_arm), .ctl_abort(ctl_abort),
        .sts_state(sts_state), .sts_trg_adr(sts_trg_adr),
        .sti_tready(sti_tready), .sti_tvalid(sti_tvalid),
        .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
        .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast),
        .sto_tevent(sto_tevent), .sto_tdata(sto_tdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Trigger-class event on the trigger sample, a masked-out event on every data%7==5.
    function automatic logic [1:0] evtOf(input int d, input int trgD);
        if (d == trgD) return 2'b10;
        if (d % 7 == 5) return 2'b01;
        return 2'b00;
    endfunction

    task automatic armPulse();
        ctl_arm = 1'b1;
        @(negedge clk);
        ctl_arm = 1'b0;
    endtask

    task automatic applyStimulus(input int count, input int startVal, input int trgD, input int armAt);
        int  i = 0;
        int  cyc = 0;
        logic acc;
        while (i < count && cyc < 200 && sts_state != 2'd3) begin
            sti_tvalid = 1'b1;
            sti_tdata  = SDW'(startVal + i);
            sti_tevent = evtOf(startVal + i, trgD);
            ctl_arm    = (i == armAt);
            acc        = sti_tready;
            @(negedge clk);
            cyc++;
            if (acc) i++;
        end
        sti_tvalid = 1'b0;
        sti_tevent = '0;
        ctl_arm    = 1'b0;
    endtask

    task automatic readout(input int n, input int first, input int trgD, input bit randomRdy, input int stopAfter);
        int k = 0;
        int cyc = 0;
        int firstSeen = -1;
        int lastCyc = 0;
        bit stalled = 0;
        bit done = 0;
        bit rdy;
        logic [SDW-1:0] sData;
        logic [SEW-1:0] sEvt;
        logic           sLast;
        while (!done && cyc < 300) begin
            if (stalled) begin
                checkOutput("stallValid", sto_tvalid, 1'b1);
                checkOutput("stallData", sto_tdata, sData);
                checkOutput("stallEvent", sto_tevent, sEvt);
                checkOutput("stallLast", sto_tlast, sLast);
            end
            if (sts_state == 2'd3) checkOutput("inputStalled", sti_tready, 1'b0);
            rdy = randomRdy ? 1'($urandom_range(0, 1)) : 1'b1;
            sto_tready = rdy;
            if (sto_tvalid) begin
                if (firstSeen < 0) begin
                    firstSeen = cyc;
                    checkOutput("firstValidLatency", cyc <= 2, 1'b1);
                end
                if (rdy) begin
                    checkOutput("beatData", sto_tdata, SDW'(first + k));
                    checkOutput("beatEvent", sto_tevent, evtOf(first + k, trgD));
                    checkOutput("beatLast", sto_tlast, k == n - 1);
                    k++;
                    stalled = 0;
                    lastCyc = cyc;
                    if (k == stopAfter || sto_tlast) done = 1;
                end else begin
                    stalled = 1;
                    sData = sto_tdata;
                    sEvt  = sto_tevent;
                    sLast = sto_tlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        sto_tready = 1'b0;
        checkOutput("readoutDone", done, 1'b1);
        checkOutput("beatCount", k, stopAfter);
        if (k == n) begin
            checkOutput("backToIdle", sts_state, 2'd0);
            if (!randomRdy) checkOutput("gapless", lastCyc - firstSeen, n - 1);
        end
    endtask

    initial begin
        rst         = 1'b0;
        cfg_evt_trg = 2'b10;
        cfg_post    = 4'd3;
        ctl_arm     = 1'b0;
        ctl_abort   = 1'b0;
        sti_tvalid  = 1'b0;
        sti_tevent  = '0;
        sti_tdata   = '0;
        sto_tready  = 1'b0;
        #12;
        checkOutput("rstState", sts_state, 2'd0);
        checkOutput("rstTrgAdr", sts_trg_adr, 4'd0);
        checkOutput("rstValid", sto_tvalid, 1'b0);
        checkOutput("rstLast", sto_tlast, 1'b0);
        checkOutput("rstData", sto_tdata, 32'd0);
        checkOutput("rstEvent", sto_tevent, 2'd0);
        checkOutput("rstInReady", sti_tready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] basic capture with pre-arm discard and arm during POST");
        applyStimulus(5, 'h100, 'h100, -1);
        checkOutput("idleDiscard", sts_state, 2'd0);
        armPulse();
        checkOutput("armed", sts_state, 2'd1);
        applyStimulus(20, 0, 10, 12);
        checkOutput("enterRead1", sts_state, 2'd3);
        checkOutput("trgAdr1", sts_trg_adr, 4'd10);
        readout(14, 0, 10, 1'b0, 14);

        $display("[TB] wrap capture");
        armPulse();
        applyStimulus(40, 0, 25, -1);
        checkOutput("enterRead2", sts_state, 2'd3);
        checkOutput("trgAdr2", sts_trg_adr, 4'd9);
        readout(16, 13, 25, 1'b0, 16);

        $display("[TB] wrap capture with random output ready");
        armPulse();
        applyStimulus(40, 0, 25, -1);
        checkOutput("enterRead3", sts_state, 2'd3);
        readout(16, 13, 25, 1'b1, 16);

        $display("[TB] post=0 trigger on first sample");
        cfg_post = 4'd0;
        armPulse();
        applyStimulus(3, 'h55, 'h55, -1);
        checkOutput("enterRead4", sts_state, 2'd3);
        checkOutput("trgAdr4", sts_trg_adr, 4'd0);
        readout(1, 'h55, 'h55, 1'b0, 1);
        cfg_post = 4'd3;

        $display("[TB] abort mid-readout, abort beats arm, re-arm");
        armPulse();
        applyStimulus(40, 0, 25, -1);
        readout(16, 13, 25, 1'b0, 4);
        ctl_abort = 1'b1;
        @(negedge clk);
        ctl_abort = 1'b0;
        checkOutput("abortValid", sto_tvalid, 1'b0);
        checkOutput("abortState", sts_state, 2'd0);
        ctl_abort = 1'b1;
        ctl_arm   = 1'b1;
        @(negedge clk);
        ctl_abort = 1'b0;
        ctl_arm   = 1'b0;
        checkOutput("abortOverArm", sts_state, 2'd0);
        armPulse();
        applyStimulus(20, 0, 10, -1);
        checkOutput("enterRead5", sts_state, 2'd3);
        checkOutput("trgAdr5", sts_trg_adr, 4'd10);
        readout(14, 0, 10, 1'b0, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
